// File: rtl/task2.sv
// task2: single-port RAM with registered read, output-enable gating and async clear
module task2 #(
    parameter int p_data_width    = 8,
    parameter int p_address_width = 10
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset_n,
    input  logic [p_address_width-1:0] i_w_address,
    input  logic [p_data_width-1:0]    i_w_in,
    input  logic                       i_w_we,
    input  logic                       i_w_oe,
    output logic [p_data_width-1:0]    o_w_out
);
    localparam int depth = 1 << p_address_width;
    logic [p_data_width-1:0] mem [depth];
    logic [depth-1:0]        valid;
    logic [p_data_width-1:0] r_data;
    // data array is never cleared; the valid bits mask stale words
    always_ff @(posedge i_w_clk)
        if (i_w_we) mem[i_w_address] <= i_w_in;
    // valid bits and read register, cleared asynchronously; write-through on we
    always_ff @(posedge i_w_clk or negedge i_w_reset_n)
        if (!i_w_reset_n) begin
            valid  <= '0;
            r_data <= '0;
        end else begin
            if (i_w_we) valid[i_w_address] <= 1'b1;
            if (i_w_oe) r_data <= i_w_we ? i_w_in : (valid[i_w_address] ? mem[i_w_address] : '0);
        end
    assign o_w_out = i_w_oe ? r_data : '0;
endmodule

// File: tb/tb_task2.sv
// tb_task2: directed self-checking bench for task2
module tb_task2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] addr;
    logic [7:0] din;
    logic       we;
    logic       oe;
    logic [7:0] dout;
    int errors = 0;
    int checks = 0;

    task2 dut (
        .i_w_clk(clk),
        .i_w_reset_n(rst_n),
        .i_w_address(addr),
        .i_w_in(din),
        .i_w_we(we),
        .i_w_oe(oe),
        .o_w_out(dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; oe = 1'b1; we = 1'b1; addr = 10'd2; din = 8'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout !== 8'h00) begin errors++; $display("FAIL reset_hold%0d got=%h exp=00", i, dout); end
        end
        rst_n = 1'b1; we = 1'b0;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_write_ignored got=%h exp=00", dout); end
    endtask

    task automatic test_unwritten();
        oe = 1'b1; we = 1'b0; addr = 10'd3;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL unwritten_3 got=%h exp=00", dout); end
        addr = 10'd2;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL unwritten_2 got=%h exp=00", dout); end
    endtask

    task automatic test_write_oe_off();
        oe = 1'b0; we = 1'b1; addr = 10'd2; din = 8'd2;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL oe_off_comb got=%h exp=00", dout); end
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL oe_off_w2 got=%h exp=00", dout); end
        addr = 10'd3; din = 8'd3;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL oe_off_w3 got=%h exp=00", dout); end
        oe = 1'b1; we = 1'b0; addr = 10'd2;
        tick();
        checks++;
        if (dout !== 8'h02) begin errors++; $display("FAIL read_back_2 got=%h exp=02", dout); end
        addr = 10'd3;
        tick();
        checks++;
        if (dout !== 8'h03) begin errors++; $display("FAIL read_back_3 got=%h exp=03", dout); end
    endtask

    task automatic test_write_through();
        oe = 1'b1; we = 1'b1; addr = 10'd2; din = 8'd2;
        tick();
        checks++;
        if (dout !== 8'h02) begin errors++; $display("FAIL wt_2 got=%h exp=02", dout); end
        addr = 10'd3; din = 8'd3;
        tick();
        checks++;
        if (dout !== 8'h03) begin errors++; $display("FAIL wt_3 got=%h exp=03", dout); end
        we = 1'b0; oe = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL oe_drop got=%h exp=00", dout); end
        oe = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h03) begin errors++; $display("FAIL oe_restore got=%h exp=03", dout); end
    endtask

    task automatic test_full_range();
        oe = 1'b1; we = 1'b1; addr = 10'd0; din = 8'hA5;
        tick();
        addr = 10'd1023; din = 8'h5A;
        tick();
        we = 1'b0; addr = 10'd0;
        tick();
        checks++;
        if (dout !== 8'hA5) begin errors++; $display("FAIL range_0 got=%h exp=a5", dout); end
        addr = 10'd1023;
        tick();
        checks++;
        if (dout !== 8'h5A) begin errors++; $display("FAIL range_1023 got=%h exp=5a", dout); end
        addr = 10'd512;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL range_512 got=%h exp=00", dout); end
    endtask

    task automatic test_async_reset();
        logic [9:0] addrs [4];
        addrs = '{10'd2, 10'd3, 10'd0, 10'd1023};
        oe = 1'b1; we = 1'b0; addr = 10'd0;
        tick();
        checks++;
        if (dout !== 8'hA5) begin errors++; $display("FAIL pre_reset got=%h exp=a5", dout); end
        we = 1'b1; addr = 10'd5; din = 8'h99;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL async_clear got=%h exp=00", dout); end
        #1 rst_n = 1'b1;
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = addrs[i];
            tick();
            checks++;
            if (dout !== 8'h00) begin errors++; $display("FAIL post_reset_%0d got=%h exp=00", addrs[i], dout); end
        end
        addr = 10'd5;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL discarded_5 got=%h exp=00", dout); end
    endtask

    initial begin
        rst_n = 1'b0; oe = 1'b0; we = 1'b0; addr = '0; din = '0;
        test_reset();
        test_unwritten();
        test_write_oe_off();
        test_write_through();
        test_full_range();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
